// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues data-memory accesses, stalls the pipeline
// while memory is busy, aborts after TIMEOUT wait cycles and registers writeback.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_in,
    input  logic [3:0]  dst_addr_in,
    input  logic [15:0] alu_in,
    input  logic        Mem_re_in,
    input  logic        Mem_we_in,
    input  logic [15:0] d_addr_in,
    input  logic [15:0] wrt_data_in,
    input  logic        dmem_rdy,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        mem_stall,
    output logic        wb_we,
    output logic [3:0]  wb_dst_addr,
    output logic [15:0] wb_data,
    output logic        mem_err
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_wb_we;
    logic [3:0]  r_wb_dst_addr;
    logic [15:0] r_wb_data;
    logic        r_mem_err;

    logic        w_mem_op;
    logic        w_is_load;
    logic        w_abort;
    logic        w_stall;

    // A simultaneous read+write request is a store; the read side is suppressed.
    always_comb begin
        w_mem_op  = Mem_re_in | Mem_we_in;
        w_is_load = Mem_re_in & ~Mem_we_in;
        w_abort   = (r_state == WAIT) && (r_cnt == LP_TIMEOUT);
        w_stall   = w_mem_op & ~dmem_rdy & ~w_abort;
    end

    assign dmem_addr   = d_addr_in;
    assign dmem_wdata  = wrt_data_in;
    assign dmem_re     = w_is_load & ~w_abort & ~rst;
    assign dmem_we     = Mem_we_in & ~w_abort & ~rst;
    assign mem_stall   = w_stall;
    assign wb_we       = r_wb_we;
    assign wb_dst_addr = r_wb_dst_addr;
    assign wb_data     = r_wb_data;
    assign mem_err     = r_mem_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wb_we       <= 1'b0;
            r_wb_dst_addr <= '0;
            r_wb_data     <= '0;
            r_mem_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op && !dmem_rdy) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_rdy || w_abort) begin
                        r_state <= IDLE;
                    end else if (r_cnt != LP_TIMEOUT) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A stalled cycle commits a bubble; the op commits once when it completes.
            if (w_stall) begin
                r_wb_we <= 1'b0;
            end else begin
                r_wb_we       <= we_in & ~(w_abort & w_is_load);
                r_wb_dst_addr <= dst_addr_in;
                r_wb_data     <= (w_is_load && dmem_rdy) ? dmem_rdata : alu_in;
            end

            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have a single clock `clk`. Reset `rst` SHALL be synchronous and active-high; all state changes occur on posedge clk.
REQ-002 SHALL have the following ports; all inputs come from the EX_MEM pipe register:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we_in  in  1  register-file write enable of the current op
- dst_addr_in  in  4  destination register
- alu_in  in  16  ALU result
- Mem_re_in  in  1  load request
- Mem_we_in  in  1  store request
- d_addr_in  in  16  data address
- wrt_data_in  in  16  store data
- dmem_rdy  in  1  data memory completes the access this cycle
- dmem_rdata  in  16  load data, valid when dmem_rdy=1
- dmem_re  out  1  memory read strobe
- dmem_we  out  1  memory write strobe
- dmem_addr  out  16  memory address
- dmem_wdata  out  16  memory write data
- mem_stall  out  1  stalls the EX_MEM register and all upstream stages
- wb_we  out  1  writeback enable (registered)
- wb_dst_addr  out  4  writeback register (registered)
- wb_data  out  16  writeback data (registered)
- mem_err  out  1  sticky timeout flag
REQ-003 SHALL have the parameter TIMEOUT, default 255, which sets the number of WAIT cycles before an access is aborted.

Function
REQ-004 mem_op SHALL be defined as Mem_re_in | Mem_we_in. When both are set, the op SHALL be treated as a store only (dmem_re=0).
REQ-005 dmem_addr SHALL equal d_addr_in and dmem_wdata SHALL equal wrt_data_in, combinationally.
REQ-006 dmem_re and dmem_we SHALL be asserted combinationally while mem_op=1, in both IDLE and WAIT. They SHALL be 0 in the cycle in which a timeout abort occurs.
REQ-007 mem_stall SHALL equal mem_op & ~dmem_rdy & ~abort, combinationally. abort SHALL be 1 when state=WAIT and cnt=TIMEOUT.
REQ-008 The FSM SHALL have two states, IDLE and WAIT.
- IDLE→WAIT when mem_op & ~dmem_rdy.
- WAIT→IDLE when dmem_rdy or abort.
- Otherwise the state holds.
REQ-009 cnt SHALL be an 8-bit counter.
- Cleared on entry to WAIT.
- Incremented each WAIT cycle without dmem_rdy.
- Saturates at TIMEOUT.
REQ-010 A zero-wait access (dmem_rdy=1 in the first cycle) SHALL complete in 1 cycle with mem_stall=0 and no WAIT entry.
REQ-011 Writeback register update when mem_stall=0:
- wb_we<=we_in & ~(abort & Mem_re_in & ~Mem_we_in)
- wb_dst_addr<=dst_addr_in
- wb_data<=dmem_rdata for a load completing with dmem_rdy; otherwise alu_in
REQ-012 When mem_stall=1, the writeback register SHALL load a bubble: wb_we<=0, with wb_dst_addr and wb_data holding their values.
REQ-013 Writeback latency SHALL be exactly 1 cycle after the non-stalled cycle that completes the op.
REQ-014 mem_err SHALL be set on abort and cleared only by rst. Each op SHALL be issued to memory exactly once; a stall never causes a duplicate commit.

Reset
REQ-015 When rst=1, the next state SHALL be:
- state=IDLE, cnt=0
- wb_we=0, wb_dst_addr=0, wb_data=0
- mem_err=0
REQ-016 A reset asserted during WAIT SHALL abandon the access without any writeback. While rst=1, dmem_re and dmem_we SHALL be forced to 0.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Non-memory op: we_in=1, dst=3, alu=0x1234 -> next cycle wb_we=1, wb_dst_addr=3, wb_data=0x1234, mem_stall never 1.
- Zero-wait load: Mem_re=1, addr=0x0040, dmem_rdy=1, rdata=0xBEEF, dst=5 -> mem_stall=0; next cycle wb_data=0xBEEF, wb_we=1.
- 3-wait store: Mem_we=1, addr=0x0100, data=0x00AA, rdy on cycle 4 -> mem_stall=1 for 3 cycles, dmem_we=1 for 4 cycles, wb_we=0 during the stall.
- Load timeout: Mem_re=1, rdy never -> abort after TIMEOUT WAIT cycles, mem_err=1, wb_we=0, next op proceeds.
- Re+we both set -> dmem_we=1, dmem_re=0 throughout.
- rst asserted during WAIT -> next cycle state=IDLE, wb_we=0, no writeback occurs.
